config_loader: RTL and testbench

- Transmit-side driver of the tile configuration interface, i.e. the `config_data` / `config_en` pair consumed by each switch box and PE tile.
- Receives a serial bitstream (address header + 32-bit data word per frame), assembles each frame and commits it to one tile with a one-cycle `config_en` pulse.
- Sits between the off-chip programming pin interface and the fabric tile array.

---
 rtl/fabric_cfg_pkg.sv | 21 ++
 rtl/cfg_shift_reg.sv | 44 ++++
 rtl/config_loader.sv | 198 +++++++++++++++++++
 tb/tb_config_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared configuration-fabric definitions used by the loader, the tile side and the bench.
//   CFG_DATA_W   : width of a tile configuration word
//   CFG_ADDR_W   : width of the tile address field of a frame
//   CFG_END_ADDR : reserved address that terminates a load sequence
//   cfg_state_t  : loader FSM states
package fabric_cfg_pkg;

  localparam int unsigned CFG_DATA_W = 32;
  localparam int unsigned CFG_ADDR_W = 8;
  localparam logic [CFG_ADDR_W-1:0] CFG_END_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } cfg_state_t;

endpackage : fabric_cfg_pkg

// File: rtl/cfg_shift_reg.sv
// Serial-in parallel-out shift register with bit counter, shared by the
// address and data fields of a frame.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   clear      : zero the contents and the bit counter (wins over shift_en)
//   shift_en   : shift bit_in into the LSB this cycle
//   bit_in     : serial data, MSB of the field first
//   len        : number of bits in the field currently being assembled
//   data       : assembled contents
//   full_c     : the shift happening this cycle completes a field of len bits
module cfg_shift_reg #(
  parameter  int unsigned W  = 32,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          shift_en,
  input  logic          bit_in,
  input  logic [CW-1:0] len,
  output logic [W-1:0]  data,
  output logic          full_c
);

  logic [CW-1:0] count;

  // Shift register and bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift_en) begin
      data  <= {data[W-2:0], bit_in};
      count <= count + CW'(1);
    end
  end

  // Independent of clear so the parent can use it to decide when to clear
  assign full_c = shift_en && (count == len - CW'(1));

endmodule : cfg_shift_reg

// File: rtl/config_loader.sv
// Transmit-side driver of the tile configuration interface. Assembles serial
// frames (address header + data word, MSB first) and commits each word to one
// tile with a single-cycle one-hot config_en strobe.
// Build option: define CONFIG_LOADER_PARITY_EN to add a trailing even-parity
// bit per frame, covering address + data.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   cfg_start    : pulse; begins or restarts a load sequence
//   cfg_bit      : serial bitstream, MSB first
//   cfg_valid    : cfg_bit valid this cycle
//   cfg_ready    : loader accepts a bit this cycle
//   config_data  : configuration word broadcast to all tiles
//   config_en    : one-hot commit strobe, bit i writes tile i
//   load_done    : sticky, terminating address received
//   load_error   : sticky, bad address (or bad parity)
//   words_loaded : successful commits since the last start, saturating
module config_loader
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned       NUM_TILES = 16,
  parameter int unsigned       ADDR_W    = CFG_ADDR_W,
  parameter int unsigned       DATA_W    = CFG_DATA_W,
  parameter logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(CFG_END_ADDR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic                 cfg_bit,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [DATA_W-1:0]    config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 load_done,
  output logic                 load_error,
  output logic [15:0]          words_loaded
);

  localparam int unsigned CW   = $clog2(DATA_W + 1);
  localparam int unsigned WL_W = 16;

  cfg_state_t state_q, state_next;

  logic              accept;
  logic              sr_clear;
  logic              sr_shift;
  logic [CW-1:0]     sr_len;
  logic [DATA_W-1:0] sr_data;
  logic              sr_full;
  logic [ADDR_W-1:0] addr_word;
  logic              addr_in_range;

  logic [ADDR_W-1:0] addr_q, addr_next;
  logic              addr_ok_q, addr_ok_next;
  logic              commit_ok;

  logic                 cfg_ready_next;
  logic [DATA_W-1:0]    config_data_next;
  logic [NUM_TILES-1:0] config_en_next;
  logic                 load_done_next;
  logic                 load_error_next;
  logic [WL_W-1:0]      words_loaded_next;

`ifdef CONFIG_LOADER_PARITY_EN
  logic parity_ok_q, parity_ok_next;
  assign commit_ok = addr_ok_q && parity_ok_q;
`else
  assign commit_ok = addr_ok_q;
`endif

  assign accept = cfg_valid && cfg_ready;

  // One shifter serves both fields; it is cleared as each address completes,
  // after each commit and on every start.
  assign sr_shift = accept && ((state_q == ADDR) || (state_q == DATA));
  assign sr_len   = (state_q == DATA) ? CW'(DATA_W) : CW'(ADDR_W);
  assign sr_clear = cfg_start || ((state_q == ADDR) && sr_full) || (state_q == COMMIT);

  cfg_shift_reg #(.W(DATA_W)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .clear    (sr_clear),
    .shift_en (sr_shift),
    .bit_in   (cfg_bit),
    .len      (sr_len),
    .data     (sr_data),
    .full_c   (sr_full)
  );

  // Address including the bit being accepted on this edge
  assign addr_word     = {sr_data[ADDR_W-2:0], cfg_bit};
  assign addr_in_range = 32'(addr_word) < NUM_TILES;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // Next-state logic; a start overrides everything, including a pending commit
  always_comb begin
    state_next = state_q;
    if (cfg_start) begin
      state_next = ADDR;
    end else begin
      case (state_q)
        IDLE:   state_next = IDLE;
        ADDR:   if (sr_full) state_next = (addr_word == END_ADDR) ? DONE : DATA;
`ifdef CONFIG_LOADER_PARITY_EN
        DATA:   if (sr_full) state_next = PARITY;
`else
        DATA:   if (sr_full) state_next = COMMIT;
`endif
        PARITY: if (accept) state_next = COMMIT;
        COMMIT: state_next = ADDR;
        DONE:   state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    cfg_ready_next    = (state_next == ADDR) || (state_next == DATA) || (state_next == PARITY);
    config_data_next  = config_data;
    config_en_next    = '0;
    load_done_next    = load_done;
    load_error_next   = load_error;
    words_loaded_next = words_loaded;
    addr_next         = addr_q;
    addr_ok_next      = addr_ok_q;
`ifdef CONFIG_LOADER_PARITY_EN
    parity_ok_next    = parity_ok_q;
`endif
    if (cfg_start) begin
      load_done_next    = 1'b0;
      load_error_next   = 1'b0;
      words_loaded_next = '0;
    end else begin
      case (state_q)
        ADDR: begin
          if (sr_full) begin
            addr_next    = addr_word;
            addr_ok_next = addr_in_range;
            if (addr_word == END_ADDR) load_done_next = 1'b1;
            else if (!addr_in_range)   load_error_next = 1'b1;
          end
        end
`ifdef CONFIG_LOADER_PARITY_EN
        PARITY: begin
          if (accept) begin
            parity_ok_next = ((^{addr_q, sr_data}) == cfg_bit);
            if ((^{addr_q, sr_data}) != cfg_bit) load_error_next = 1'b1;
          end
        end
`endif
        COMMIT: begin
          // Rejected frames leave config_data untouched so tiles only ever see committed words
          if (commit_ok) begin
            config_data_next = sr_data;
            config_en_next   = NUM_TILES'(1) << addr_q;
            if (words_loaded != '1) words_loaded_next = words_loaded + WL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_ready    <= 1'b0;
      config_data  <= '0;
      config_en    <= '0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      addr_q       <= '0;
      addr_ok_q    <= 1'b0;
`ifdef CONFIG_LOADER_PARITY_EN
      parity_ok_q  <= 1'b0;
`endif
    end else begin
      cfg_ready    <= cfg_ready_next;
      config_data  <= config_data_next;
      config_en    <= config_en_next;
      load_done    <= load_done_next;
      load_error   <= load_error_next;
      words_loaded <= words_loaded_next;
      addr_q       <= addr_next;
      addr_ok_q    <= addr_ok_next;
`ifdef CONFIG_LOADER_PARITY_EN
      parity_ok_q  <= parity_ok_next;
`endif
    end
  end

endmodule : config_loader

// File: tb/tb_config_loader.sv
// Directed self-checking bench for config_loader. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_config_loader;
  import fabric_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic        cfg_bit;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;
  bit gappy = 1'b0;

  logic [15:0] cap_en_q[$];
  logic [31:0] cap_data_q[$];
  int          dup_n   = 0;
  logic [15:0] prev_en = '0;

  always #5 clk = ~clk;

  config_loader #(.NUM_TILES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_start    (cfg_start),
    .cfg_bit      (cfg_bit),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .config_data  (config_data),
    .config_en    (config_en),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  // Strobe monitor: logs every commit and counts strobes longer than one cycle
  always @(negedge clk) begin
    if (config_en != 16'h0) begin
      cap_en_q.push_back(config_en);
      cap_data_q.push_back(config_data);
      if (prev_en != 16'h0) dup_n++;
    end
    prev_en = config_en;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    int n;
    int idle;
    n = 0;
    if (gappy) begin
      idle = int'($urandom_range(0, 1));
      repeat (idle) begin
        cfg_valid = 1'b0;
        cfg_bit   = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    while (cfg_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL send_bit_timeout: cfg_ready=%b required 1", cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_fields(input logic [7:0] a, input logic [31:0] d);
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    for (int i = 31; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d);
    send_fields(a, d);
`ifdef CONFIG_LOADER_PARITY_EN
    send_bit(^{a, d});
`endif
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cfg_ready); end
    total++; if (config_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", config_data); end
    total++; if (config_en !== 16'h0) begin bad++; $display("FAIL rst_en: got %h want 0", config_en); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", load_done); end
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", load_error); end
    total++; if (words_loaded !== 16'h0) begin bad++; $display("FAIL rst_words: got %h want 0", words_loaded); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %b want 0", cfg_ready); end
    cfg_valid = 1'b1;
    repeat (3) @(negedge clk);
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL idle_ignore: got %b want 0", cfg_ready); end
  endtask

  task automatic test_single();
    pulse_start();
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL start_ready: got %b want 1", cfg_ready); end
    send_frame(8'h03, 32'hDEADBEEF);
    total++; if (config_en !== 16'h0) begin bad++; $display("FAIL single_early: got %h want 0", config_en); end
    @(negedge clk);
    total++; if (config_en !== 16'h0008) begin bad++; $display("FAIL single_en: got %h want 0008", config_en); end
    total++; if (config_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", config_data); end
    total++; if (words_loaded !== 16'd1) begin bad++; $display("FAIL single_words: got %0d want 1", words_loaded); end
    @(negedge clk);
    total++; if (config_en !== 16'h0) begin bad++; $display("FAIL single_pulse_len: got %h want 0", config_en); end
    total++; if (config_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_hold: got %h want deadbeef", config_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] endw;
    endw = CFG_END_ADDR;
    pulse_start();
    cap_en_q.delete(); cap_data_q.delete(); dup_n = 0;
    send_frame(8'h00, 32'hA5A50000);
    send_frame(8'h0F, 32'h0F0F1234);
    send_frame(8'h07, 32'h80000001);
    for (int i = 7; i >= 0; i--) send_bit(endw[i]);
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", load_done); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready: got %b want 0", cfg_ready); end
    total++; if (words_loaded !== 16'd3) begin bad++; $display("FAIL b2b_words: got %0d want 3", words_loaded); end
    repeat (3) @(negedge clk);
    total++; if (cap_en_q.size() !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", cap_en_q.size()); end
    if (cap_en_q.size() == 3) begin
      total++; if (cap_en_q[0] !== 16'h0001 || cap_data_q[0] !== 32'hA5A50000) begin bad++; $display("FAIL b2b_f0: got %h/%h want 0001/a5a50000", cap_en_q[0], cap_data_q[0]); end
      total++; if (cap_en_q[1] !== 16'h8000 || cap_data_q[1] !== 32'h0F0F1234) begin bad++; $display("FAIL b2b_f1: got %h/%h want 8000/0f0f1234", cap_en_q[1], cap_data_q[1]); end
      total++; if (cap_en_q[2] !== 16'h0080 || cap_data_q[2] !== 32'h80000001) begin bad++; $display("FAIL b2b_f2: got %h/%h want 0080/80000001", cap_en_q[2], cap_data_q[2]); end
    end
    total++; if (dup_n !== 0) begin bad++; $display("FAIL b2b_single_cycle: got %0d long strobes want 0", dup_n); end
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL b2b_done_sticky: got %b want 1", load_done); end
  endtask

  task automatic test_bad_addr();
    pulse_start();
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL start_clr_done: got %b want 0", load_done); end
    send_frame(8'h20, 32'h12345678);
    total++; if (load_error !== 1'b1) begin bad++; $display("FAIL bad_error: got %b want 1", load_error); end
    @(negedge clk);
    total++; if (config_en !== 16'h0) begin bad++; $display("FAIL bad_en: got %h want 0", config_en); end
    total++; if (config_data !== 32'h80000001) begin bad++; $display("FAIL bad_data_held: got %h want 80000001", config_data); end
    total++; if (words_loaded !== 16'd0) begin bad++; $display("FAIL bad_words: got %0d want 0", words_loaded); end
    send_frame(8'h02, 32'hCAFEF00D);
    @(negedge clk);
    total++; if (config_en !== 16'h0004) begin bad++; $display("FAIL after_bad_en: got %h want 0004", config_en); end
    total++; if (config_data !== 32'hCAFEF00D) begin bad++; $display("FAIL after_bad_data: got %h want cafef00d", config_data); end
    total++; if (words_loaded !== 16'd1) begin bad++; $display("FAIL after_bad_words: got %0d want 1", words_loaded); end
    total++; if (load_error !== 1'b1) begin bad++; $display("FAIL error_sticky: got %b want 1", load_error); end
  endtask

  task automatic test_gappy();
    pulse_start();
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL start_clr_error: got %b want 0", load_error); end
    gappy = 1'b0;
    send_frame(8'h05, 32'h13579BDF);
    @(negedge clk);
    total++; if (config_en !== 16'h0020 || config_data !== 32'h13579BDF) begin bad++; $display("FAIL cont_commit: got %h/%h want 0020/13579bdf", config_en, config_data); end
    gappy = 1'b1;
    send_frame(8'h05, 32'h13579BDF);
    gappy = 1'b0;
    @(negedge clk);
    total++; if (config_en !== 16'h0020 || config_data !== 32'h13579BDF) begin bad++; $display("FAIL gappy_commit: got %h/%h want 0020/13579bdf", config_en, config_data); end
    total++; if (words_loaded !== 16'd2) begin bad++; $display("FAIL gappy_words: got %0d want 2", words_loaded); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    a = 8'h09;
    @(negedge clk);
    cap_en_q.delete(); cap_data_q.delete();
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    #2 reset = 1'b0;
    #1;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL async_ready: got %b want 0", cfg_ready); end
    total++; if (config_data !== 32'h0) begin bad++; $display("FAIL async_data: got %h want 0", config_data); end
    total++; if (words_loaded !== 16'h0) begin bad++; $display("FAIL async_words: got %0d want 0", words_loaded); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cap_en_q.size() !== 0) begin bad++; $display("FAIL async_no_strobe: got %0d strobes want 0", cap_en_q.size()); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL async_idle: got %b want 0", cfg_ready); end
    pulse_start();
    send_frame(8'h09, 32'h0BADCAFE);
    @(negedge clk);
    total++; if (config_en !== 16'h0200 || config_data !== 32'h0BADCAFE) begin bad++; $display("FAIL post_rst_commit: got %h/%h want 0200/0badcafe", config_en, config_data); end
    total++; if (words_loaded !== 16'd1) begin bad++; $display("FAIL post_rst_words: got %0d want 1", words_loaded); end
  endtask

  task automatic test_start_collide();
    logic [7:0]  a;
    logic [31:0] d;
    a = 8'h04;
    d = 32'hFFFF0000;
    pulse_start();
    send_frame(8'h01, 32'h11112222);
    @(negedge clk);
    total++; if (words_loaded !== 16'd1) begin bad++; $display("FAIL pre_collide_words: got %0d want 1", words_loaded); end
    @(negedge clk);
    cap_en_q.delete(); cap_data_q.delete();
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    for (int i = 31; i >= 1; i--) send_bit(d[i]);
    cfg_valid = 1'b1; cfg_bit = d[0]; cfg_start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_start = 1'b0;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL collide_state_addr: got ready=%b want 1", cfg_ready); end
    total++; if (words_loaded !== 16'd0) begin bad++; $display("FAIL collide_words: got %0d want 0", words_loaded); end
    repeat (3) @(negedge clk);
    total++; if (cap_en_q.size() !== 0) begin bad++; $display("FAIL collide_no_strobe: got %0d strobes want 0", cap_en_q.size()); end
    send_frame(8'h06, 32'h66667777);
    @(negedge clk);
    total++; if (config_en !== 16'h0040 || config_data !== 32'h66667777) begin bad++; $display("FAIL collide_recover: got %h/%h want 0040/66667777", config_en, config_data); end
  endtask

`ifdef CONFIG_LOADER_PARITY_EN
  task automatic test_parity();
    pulse_start();
    send_fields(8'h01, 32'h00000003);
    send_bit(~(^{8'h01, 32'h00000003}));
    total++; if (load_error !== 1'b1) begin bad++; $display("FAIL parity_error: got %b want 1", load_error); end
    @(negedge clk);
    total++; if (config_en !== 16'h0) begin bad++; $display("FAIL parity_en: got %h want 0", config_en); end
    total++; if (words_loaded !== 16'd0) begin bad++; $display("FAIL parity_words: got %0d want 0", words_loaded); end
    send_frame(8'h01, 32'h00000003);
    @(negedge clk);
    total++; if (config_en !== 16'h0002) begin bad++; $display("FAIL parity_good_en: got %h want 0002", config_en); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_addr();
    test_gappy();
    test_reset_mid();
    test_start_collide();
`ifdef CONFIG_LOADER_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_config_loader
